// File: rtl/ooo_types_pkg.sv
// Shared types for the out-of-order dispatch path.
// FU classes, ROB index and the dispatch entry layout.
package ooo_types_pkg;

  localparam int DEPTH_DEF     = 4;
  localparam int PAYLOAD_W_DEF = 512;
  localparam int NUM_FU_DEF    = 5;
  localparam int ROB_IDX_W_DEF = 4;

  typedef enum logic [2:0] {
    ARITH,
    MULT,
    DIV,
    LOADSTORE,
    VECTOR
  } fu_class_t;

  typedef logic [ROB_IDX_W_DEF-1:0] rob_index_t;

  typedef struct packed {
    logic [PAYLOAD_W_DEF-1:0] payload;
    fu_class_t                fu;
    logic                     halt;
  } dispatch_entry_t;

endpackage

// File: rtl/ooo_dispatch_fifo_ram.sv
// Entry storage for the dispatch buffer.
// One write port, asynchronous read of the head slot.
module ooo_dispatch_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ooo_dispatch_buffer.sv
// Decode-to-execute dispatch queue with per-FU and ROB gating,
// flush and halt fencing.
module ooo_dispatch_buffer
  import ooo_types_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int NUM_FU    = NUM_FU_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [$clog2(NUM_FU)-1:0]  enq_fu,
  input  logic                       enq_halt,
  output logic                       deq_valid,
  output logic [PAYLOAD_W-1:0]       deq_payload,
  output logic [$clog2(NUM_FU)-1:0]  deq_fu,
  output logic [ROB_IDX_W-1:0]       deq_rob_index,
  input  logic [NUM_FU-1:0]          fu_stall,
  input  logic                       rob_ready,
  input  logic [ROB_IDX_W-1:0]       rob_index,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(NUM_FU);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = PAYLOAD_W + FW + 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]          rd_ptr;
  logic [AW:0]          wr_ptr;
  logic                 halt_pending;
  logic                 empty;
  logic                 full;
  logic                 enq_fire;
  logic                 fu_free;
  logic [EW-1:0]        head;
  logic [PAYLOAD_W-1:0] head_payload;
  logic [FW-1:0]        head_fu;
  logic                 head_halt;

  ooo_dispatch_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (CLK),
    .we    (enq_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({enq_halt, enq_fu, enq_payload}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign {head_halt, head_fu, head_payload} = head;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) &&
                 (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

  // FU codes outside the class range never match, so they read as stalled
  always_comb begin
    fu_free = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (head_fu == FW'(i)) fu_free = !fu_stall[i];
    end
  end

  assign enq_ready = !full && !halt_pending && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_valid = !empty && fu_free && rob_ready &&
                     !flush && !halted;

  assign deq_payload   = head_payload;
  assign deq_fu        = head_fu;
  assign deq_rob_index = rob_index;
  assign count         = CW'(wr_ptr - rd_ptr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (enq_halt) halt_pending <= 1'b1;
      end
      if (deq_valid) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (head_halt) halted <= 1'b1;
      end
    end
  end

  a_head_fu_range : assert property (
    @(posedge CLK) disable iff (!nRST)
    !empty |-> (int'(head_fu) < NUM_FU)
  );

endmodule

// File: doc/ooo_dispatch_buffer.md
Name: ooo_dispatch_buffer

Overview:
- Parametrised decode-to-execute dispatch queue for the out-of-order core. It replaces the single-slot decode/execute handoff with a DEPTH-entry FIFO.
- Each dequeue is gated per functional unit and by ROB allocation. Each dispatched entry is tagged with the allocated rob_index.
- The block also provides pipeline flush and halt-instruction fencing.
- Sits between the decode stage (enqueue side) and the execute/issue stage (dequeue side).

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- PAYLOAD_W, 512, width of the opaque packed decode bundle (control-signal structs, pc, immediate, operands).
- NUM_FU, 5, number of functional-unit classes (arith, mult, div, loadstore, vector).
- ROB_IDX_W, 4, width of a ROB index.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (mispredict/exception).
- enq_valid  in  1  decode presents an entry.
- enq_ready  out  1  buffer can accept.
- enq_payload  in  PAYLOAD_W  decode bundle.
- enq_fu  in  $clog2(NUM_FU)  target FU class.
- enq_halt  in  1  entry is a halt instruction.
- deq_valid  out  1  head entry dispatched this cycle.
- deq_payload  out  PAYLOAD_W  head bundle.
- deq_fu  out  $clog2(NUM_FU)  head FU class.
- deq_rob_index  out  ROB_IDX_W  ROB slot for the dispatched entry.
- fu_stall  in  NUM_FU  per-FU busy; bit i blocks dispatch to class i.
- rob_ready  in  1  ROB has a free slot.
- rob_index  in  ROB_IDX_W  ROB tail index offered this cycle.
- count  out  $clog2(DEPTH+1)  occupancy.
- halted  out  1  a halt entry has been dispatched.

Behaviour:
- Storage and pointers:
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits wide.
  - empty when the pointers are equal. full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Reset (async, nRST=0): both pointers 0, halt_pending=0, halted=0. Outputs: enq_ready=1, deq_valid=0, count=0, halted=0. Payload storage is not reset; deq_payload is don't-care while deq_valid=0.
- Enqueue:
  - enq_fire = enq_valid & enq_ready.
  - enq_ready = !full & !halt_pending & !flush. enq_ready does not depend combinationally on deq_valid, so there is no full-bypass.
  - On enq_fire the entry is written at wr_ptr and wr_ptr increments.
  - If enq_halt is set, halt_pending is also set.
- Dequeue:
  - deq_valid = !empty & !fu_stall[head.fu] & rob_ready & !flush & !halted.
  - Execute accepts unconditionally, so deq_valid means fire: rd_ptr increments.
  - deq_rob_index = rob_index, passed through combinationally. The ROB allocates when it sees deq_valid.
- Latency: enqueue to earliest dequeue is 1 cycle. There is no same-cycle bypass into an empty queue.
- Simultaneous enqueue and dequeue: allowed whenever not full, and count is unchanged. When full, only dequeue fires that cycle; enq_ready returns next cycle.
- Head-of-line blocking: strict in-order. A stalled head blocks younger entries even if their FU is free.
- Halt:
  - After a halt entry is enqueued, enq_ready stays 0 until flush or reset.
  - When the halt entry is dequeued, halted is set to 1 on the next edge. It is sticky and cleared only by reset.
  - While halted=1, deq_valid=0.
- Flush:
  - Synchronous. It has priority over enqueue and dequeue in the same cycle: deq_valid=0 and enq_ready=0 that cycle.
  - Next edge: rd_ptr=wr_ptr=0 and halt_pending=0. halted is unaffected.
- Reset asserted mid-operation: all state clears immediately (asynchronously); in-flight entries are lost.
- count = wr_ptr - rd_ptr in modular arithmetic, registered as pointer state (no extra cycle of lag).
- Out-of-range head FU (value ≥ NUM_FU): treated as stalled, which gives deq_valid=0. Assertion: this never occurs in simulation.

Decomposition:
- Shared package (rv32i_types_pkg or a new ooo_types_pkg):
  - fu_class_t enum: ARITH, MULT, DIV, LOADSTORE, VECTOR.
  - rob_index_t.
  - dispatch_entry_t packed struct: payload, fu, halt.
  - Default DEPTH constant.
- One natural sub-module: ooo_dispatch_fifo_ram, a DEPTH x entry register array with write port and asynchronous read port.
- Pointer, flag, and gating logic stay in the top module.

Test Plan:
- Fill/drain: with fu_stall=0 and rob_ready=0, enqueue 4 entries (DEPTH=4) → count=4, enq_ready=0. Then set rob_ready=1 → 4 consecutive deq_valid cycles in enqueue order, with deq_rob_index tracking rob_index 0..3.
- Steady stream: enqueue every cycle with dequeue enabled → count stays at 1, enq_ready stays 1 for 20 cycles, and pointers wrap cleanly past 2*DEPTH.
- FU stall: head fu=MULT, next fu=ARITH, fu_stall[MULT]=1 for 3 cycles → deq_valid=0 for those 3 cycles (ARITH entry not dispatched), then MULT then ARITH on consecutive cycles.
- Flush: 3 entries queued, assert flush together with enq_valid=1 → deq_valid=0 and enq_ready=0 that cycle; next cycle count=0, enq_ready=1.
- Halt: enqueue entries A, HALT, then attempt B → enq_ready=0 after HALT. A and HALT dispatch; halted=1 one cycle after HALT's dequeue; B is never accepted.
- Async reset mid-fill: drop nRST between clock edges with count=2 → count=0 and deq_valid=0 immediately, without waiting for a clock edge.
